// File: rtl/mux_scan_pkg.sv
//------------------------------------------------------------------------------
// Module   : mux_scan_pkg
// Purpose  : Shared types and sizes for the 4:1 mux scan controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/mux_scan_settle_cnt.sv
//------------------------------------------------------------------------------
// Module   : mux_scan_settle_cnt
// Purpose  : Loadable down-counter with zero flag, paces each select value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_settle_cnt
    import mux_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over decrement; the counter never wraps below zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mux_scan_ctrl
// Purpose  : Steps an external 4:1 mux through all channels and packs y into word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 2
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       s1,
    output logic       s0,
    output logic [3:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy
);

    localparam logic [CNT_W-1:0] C_RELOAD   = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] C_LAST_SEL = SEL_W'(NUM_CH - 1);

    scan_state_e        r_state;
    scan_state_e        w_next_state;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_CH-1:0]  r_word;
    logic               w_cnt_zero;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_capture;
    logic               w_last_ch;
    logic               w_load;
    logic               w_dec;

    assign w_capture = (r_state == ST_SCAN) && w_cnt_zero;
    assign w_last_ch = (r_sel == C_LAST_SEL);
    assign w_load    = ((r_state == ST_IDLE) && start) || (w_capture && !w_last_ch);
    assign w_dec     = (r_state == ST_SCAN) && !w_cnt_zero;

    mux_scan_settle_cnt u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_dec      (w_dec),
        .i_load_val (C_RELOAD),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start)                   w_next_state = ST_SCAN;
            ST_SCAN: if (w_capture && w_last_ch)  w_next_state = ST_DONE;
            ST_DONE: if (word_ready)              w_next_state = ST_IDLE;
            default:                              w_next_state = ST_IDLE;
        endcase
    end

    // Select and result datapath; the select stays parked on the last channel in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel  <= '0;
            r_word <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sel  <= '0;
                        r_word <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_cnt_zero) begin
                        r_word[r_sel] <= y;
                        if (!w_last_ch) begin
                            r_sel <= r_sel + SEL_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (word_ready) begin
                        r_sel <= '0;
                    end
                end
                default: begin
                    r_sel <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (r_state != ST_IDLE);
        word_valid = (r_state == ST_DONE);
        s1         = 1'b0;
        s0         = 1'b0;
        if (r_state != ST_IDLE) begin
            s1 = r_sel[1];
            s0 = r_sel[0];
        end
    end

    assign word = r_word;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mux_scan_ctrl
// Purpose  : Directed self-checking bench for mux_scan_ctrl at SETTLE_CYC 2, 1, 3.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start      [3];
    logic       word_ready [3];
    logic       y          [3];
    logic       s1         [3];
    logic       s0         [3];
    logic [3:0] word       [3];
    logic       word_valid [3];
    logic       busy       [3];

    logic [3:0] r_chan_a;
    logic [3:0] r_chan_b;
    logic       r_y_manual;

    int         checks;
    int         errors;
    logic [3:0] exp_q [$];

    // Behavioural 4:1 mux models feeding the first two instances; the third is driven directly.
    assign y[0] = r_chan_a[{s1[0], s0[0]}];
    assign y[1] = r_chan_b[{s1[1], s0[1]}];
    assign y[2] = r_y_manual;

    mux_scan_ctrl #(.SETTLE_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .y(y[0]), .s1(s1[0]), .s0(s0[0]),
        .word(word[0]), .word_valid(word_valid[0]), .word_ready(word_ready[0]), .busy(busy[0])
    );

    mux_scan_ctrl #(.SETTLE_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .y(y[1]), .s1(s1[1]), .s0(s0[1]),
        .word(word[1]), .word_valid(word_valid[1]), .word_ready(word_ready[1]), .busy(busy[1])
    );

    mux_scan_ctrl #(.SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .y(y[2]), .s1(s1[2]), .s0(s0[2]),
        .word(word[2]), .word_valid(word_valid[2]), .word_ready(word_ready[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [3:0] obs);
        logic [3:0] exp_w;
        chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            chk(tag, 32'(obs), 32'(exp_w));
        end
    endtask

    initial begin
        logic [3:0] pat;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k]      = 1'b0;
            word_ready[k] = 1'b1;
        end
        r_chan_a   = 4'b0110;
        r_chan_b   = 4'b1101;
        r_y_manual = 1'b0;

        // Reset state of every instance
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_sel",   32'({s1[k], s0[k]}), 32'd0);
            chk("rst_word",  32'(word[k]),        32'd0);
            chk("rst_valid", 32'(word_valid[k]),  32'd0);
            chk("rst_busy",  32'(busy[k]),        32'd0);
        end
        tick();

        // Scan a=0,b=1,c=1,d=0 with SETTLE_CYC=2 and an always-ready consumer
        start[0] = 1'b1;
        exp_q.push_back(4'b0110);
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_sel",   32'({s1[0], s0[0]}), 32'(i / 2));
            chk("t1_valid", 32'(word_valid[0]),  32'd0);
            chk("t1_busy",  32'(busy[0]),        32'd1);
            tick();
        end
        chk("t1_valid_hi", 32'(word_valid[0]), 32'd1);
        chk_word("t1_word", word[0]);
        tick();
        chk("t1_valid_lo", 32'(word_valid[0]),  32'd0);
        chk("t1_idle_sel", 32'({s1[0], s0[0]}), 32'd0);
        chk("t1_idle_busy", 32'(busy[0]),       32'd0);
        chk("t1_word_hold", 32'(word[0]),       32'h6);

        // Consumer stalls for five cycles with a=1,b=0,c=0,d=1
        r_chan_a      = 4'b1001;
        word_ready[0] = 1'b0;
        start[0]      = 1'b1;
        exp_q.push_back(4'b1001);
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk_word("t2_word", word[0]);
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", 32'(word_valid[0]),  32'd1);
            chk("t2_hold",  32'(word[0]),        32'h9);
            chk("t2_sel",   32'({s1[0], s0[0]}), 32'd3);
            tick();
        end
        word_ready[0] = 1'b1;
        chk("t2_valid_pre", 32'(word_valid[0]), 32'd1);
        tick();
        chk("t2_valid_drop", 32'(word_valid[0]), 32'd0);

        // start held high through the scan and the handshake cycle
        r_chan_a = 4'b1010;
        start[0] = 1'b1;
        exp_q.push_back(4'b1010);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t3_valid", 32'(word_valid[0]), 32'd0);
            chk("t3_busy",  32'(busy[0]),       32'd1);
            tick();
        end
        chk("t3_valid_hi", 32'(word_valid[0]), 32'd1);
        chk_word("t3_word", word[0]);
        tick();
        chk("t3_busy_lo",  32'(busy[0]),       32'd0);
        chk("t3_valid_lo", 32'(word_valid[0]), 32'd0);
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_quiet", 32'(busy[0]), 32'd0);
        end

        // Reset in the third cycle of a scan, with start asserted alongside it
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        rst_n    = 1'b0;
        start[0] = 1'b1;
        tick();
        rst_n    = 1'b1;
        start[0] = 1'b0;
        chk("t4_busy",  32'(busy[0]),        32'd0);
        chk("t4_word",  32'(word[0]),        32'd0);
        chk("t4_sel",   32'({s1[0], s0[0]}), 32'd0);
        chk("t4_valid", 32'(word_valid[0]),  32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t4_no_valid", 32'({busy[0], word_valid[0]}), 32'd0);
        end

        // SETTLE_CYC=1: select advances every cycle
        start[1] = 1'b1;
        exp_q.push_back(4'b1101);
        tick();
        start[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_sel",   32'({s1[1], s0[1]}), 32'(i));
            chk("t5_valid", 32'(word_valid[1]),  32'd0);
            tick();
        end
        chk("t5_valid_hi", 32'(word_valid[1]), 32'd1);
        chk_word("t5_word", word[1]);
        tick();
        chk("t5_valid_lo", 32'(word_valid[1]), 32'd0);

        // SETTLE_CYC=3: y disagrees early in each settle window, only the last cycle counts
        pat      = 4'b0101;
        start[2] = 1'b1;
        exp_q.push_back(pat);
        tick();
        start[2] = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            for (int c = 0; c < 3; c++) begin
                r_y_manual = (c == 2) ? pat[ch] : ~pat[ch];
                chk("t6_sel", 32'({s1[2], s0[2]}), 32'(ch));
                tick();
            end
        end
        chk("t6_valid_hi", 32'(word_valid[2]), 32'd1);
        chk_word("t6_word", word[2]);
        tick();
        chk("t6_valid_lo", 32'(word_valid[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, meaning cycles each select value is held before y is captured; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request one scan of all four mux channels.
REQ-005 SHALL have port y  input  1  output of the downstream 4:1 mux.
REQ-006 SHALL have port s1  output  1  mux select MSB.
REQ-007 SHALL have port s0  output  1  mux select LSB.
REQ-008 SHALL have port word  output  4  scan result; word[i] is y captured while {s1,s0}==i.
REQ-009 SHALL have port word_valid  output  1  word holds a complete scan.
REQ-010 SHALL have port word_ready  input  1  consumer accepts word.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement exactly three states: IDLE, SCAN, DONE.
REQ-013 In IDLE, {s1,s0} SHALL be 2'b00 and word_valid 0; word SHALL hold its last value.
REQ-014 start high in IDLE SHALL, at that edge, clear word to 0, set select to 0, load the settle counter with SETTLE_CYC-1 and enter SCAN.
REQ-015 In SCAN, the counter SHALL decrement each cycle; on the cycle it equals 0, y SHALL be captured into word[sel] at the closing edge.
REQ-016 At that capture edge, sel<3 SHALL increment sel (2-bit) and reload the counter; sel==3 SHALL enter DONE with select held at 2'b11.
REQ-017 Each channel SHALL occupy exactly SETTLE_CYC cycles; word_valid SHALL rise exactly 4*SETTLE_CYC cycles after the start edge.
REQ-018 In DONE, word_valid SHALL be 1 and word stable until the cycle with word_ready high; at that edge the block SHALL return to IDLE (word_valid 0 next cycle).
REQ-019 start SHALL be ignored in SCAN and DONE, including the DONE cycle where word_ready is high; a new scan needs start in IDLE.
REQ-020 word_ready outside DONE SHALL have no effect.
REQ-021 sel SHALL never exceed 3; no wrap from 3 to 0 occurs within a scan.

Reset
REQ-022 rst_n low at a rising edge SHALL, regardless of state, force IDLE, {s1,s0}=2'b00, word=4'b0000, word_valid=0, busy=0, counter=0.
REQ-023 A reset mid-scan SHALL discard partial results; no word_valid pulse SHALL follow it.
REQ-024 start asserted on the same edge as rst_n low SHALL be ignored.

Structure
REQ-025 A shared package mux_scan_pkg SHALL hold the state enum, NUM_CH=4, SEL_W=2 and CNT_W=4.
REQ-026 The settle counter SHALL be a sub-module mux_scan_settle_cnt (load, decrement, zero flag); all else SHALL stay in mux_scan_ctrl.
REQ-027 The 4:1 mux itself SHALL NOT be instantiated inside this block; s1/s0/y connect to it at the level above.

Verification
REQ-028 Bench with mux model a=0,b=1,c=1,d=0, SETTLE_CYC=2, word_ready=1: start pulse -> select sequence 00,00,01,01,10,10,11,11; word=4'b0110; word_valid high 8 cycles after start for 1 cycle.
REQ-029 Inputs a=1,b=0,c=0,d=1, word_ready=0 for 5 cycles after valid -> word=4'b1001 held stable, word_valid high all 5 cycles, {s1,s0}=11; drops the cycle after word_ready=1.
REQ-030 start re-pulsed every cycle during SCAN and during the DONE/word_ready cycle -> exactly one scan and one word_valid; busy low the cycle after handshake.
REQ-031 rst_n low at cycle 3 of a scan -> next cycle IDLE, word=0, select 00, busy 0; no word_valid in following 20 cycles without start.
REQ-032 SETTLE_CYC=1: start -> select changes every cycle 00,01,10,11; word_valid 4 cycles after start; word matches a..d.
REQ-033 Channel y changed mid-settle (SETTLE_CYC=3, y flips at settle cycle 1) -> word bit reflects y value on the final settle cycle only.
